// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
//   ctrl_state_e : FSM state encodings (RUN, LU_STALL, BR_FLUSH), also visible on ctrl_state
//   FWD_*        : EX operand-forwarding select encodings
//   REG_X0       : architectural zero register, never a hazard or forwarding source
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_BR_FLUSH = 2'b10
    } ctrl_state_e;

    localparam logic [1:0] FWD_REG = 2'b00;  // register file value
    localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM ALU result
    localparam logic [1:0] FWD_WB  = 2'b10;  // WB write-back data

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX-stage operand-forwarding select generator (purely combinational).
// Ports:
//   ex_rs1, ex_rs2      : source registers of the instruction in EX
//   mem_rd/mem_wr       : destination and write flag of the instruction in MEM
//   mem_is_load         : MEM instruction is a load (its data is not ready yet)
//   wb_rd/wb_wr         : destination and write flag of the instruction in WB
//   fwd_a, fwd_b        : operand A/B selects (FWD_REG / FWD_MEM / FWD_WB)
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_wr,
    input  logic       mem_is_load,
    input  logic [4:0] wb_rd,
    input  logic       wb_wr,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic [4:0] src   [2];
    logic [1:0] sel   [2];

    assign src[0] = ex_rs1;
    assign src[1] = ex_rs2;

    // The younger producer (MEM) wins over WB. A load in MEM has no result
    // yet, so it falls through to WB (load-use stalling covers the gap).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            always_comb begin
                sel[gi] = FWD_REG;
                if (mem_wr && (mem_rd != REG_X0) && (mem_rd == src[gi]) && !mem_is_load)
                    sel[gi] = FWD_MEM;
                else if (wb_wr && (wb_rd != REG_X0) && (wb_rd == src[gi]))
                    sel[gi] = FWD_WB;
            end
        end
    endgenerate

    assign fwd_a = sel[0];
    assign fwd_b = sel[1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Detects load-use hazards (inserting LU_BUBBLES bubbles), flushes wrong-path
// instructions when a taken branch resolves in MEM, and drives EX forwarding.
// Ports:
//   clk, rst (async, active low)
//   id_*  : ID-stage source registers and use flags
//   ex_*  : EX-stage sources, destination, load flag
//   mem_* : MEM-stage destination/write/load flags and taken-branch indication
//   wb_*  : WB-stage destination and write flag
//   pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_flush : pipeline register controls
//   fwd_a, fwd_b : EX operand forwarding selects
//   ctrl_state   : current FSM state (debug)
// Optional build macro PIPE_PERF_CNT_EN adds stall_cnt / flush_cnt outputs.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_BUBBLES = 1,   // 1..3
    parameter int CNT_W      = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic [4:0]       mem_rd,
    input  logic             mem_wr,
    input  logic             mem_is_load,
    input  logic             mem_is_branch,
    input  logic [4:0]       wb_rd,
    input  logic             wb_wr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       ctrl_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    // Remaining stall cycles after the current one while in LU_STALL.
    localparam logic [1:0] LU_LOAD = 2'(LU_BUBBLES - 1);

    ctrl_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;

    logic lu_hit;
    logic stall_c, flush_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    assign lu_hit = ex_is_load && (ex_rd != REG_X0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

    // stall_c: pc_stall + if_id_stall + id_ex_flush (bubble into EX)
    // flush_c: if_id_flush + id_ex_flush + ex_mem_flush (wrong-path squash)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        flush_c = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (mem_is_branch) begin
                    flush_c = 1'b1;
                    state_d = ST_BR_FLUSH;
                end else if (lu_hit) begin
                    stall_c = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        cnt_d   = LU_LOAD;
                        state_d = ST_LU_STALL;
                    end
                end
            end
            ST_LU_STALL: begin
                // A taken branch squashes the stalled instructions anyway,
                // so the remaining bubbles are abandoned.
                if (mem_is_branch) begin
                    flush_c = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = ST_BR_FLUSH;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = ST_RUN;
                    end
                end
            end
            // MEM and ID hold bubbles this cycle: nothing to evaluate.
            ST_BR_FLUSH: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    pipe_fwd_unit u_fwd (
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_is_load (mem_is_load),
        .wb_rd       (wb_rd),
        .wb_wr       (wb_wr),
        .fwd_a       (fwd_a_c),
        .fwd_b       (fwd_b_c)
    );

    // All controls are forced inactive while reset is asserted.
    assign pc_stall     = rst & stall_c;
    assign if_id_stall  = rst & stall_c;
    assign id_ex_flush  = rst & (stall_c | flush_c);
    assign if_id_flush  = rst & flush_c;
    assign ex_mem_flush = rst & flush_c;
    assign fwd_a        = rst ? fwd_a_c : FWD_REG;
    assign fwd_b        = rst ? fwd_b_c : FWD_REG;
    assign ctrl_state   = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Counters wrap naturally at all-ones. ex_mem_flush only rises on an
    // accepted taken branch, so it marks each counted flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall)     stall_cnt_q <= stall_cnt_q + 1'b1;
            if (ex_mem_flush) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
